// File: rtl/nibble_add_seq.sv
// Sequences a shared external 4-bit adder slice to add or subtract WIDTH-bit
// operands one nibble per clock, LSB nibble first, with valid/ready on both sides.
module nibble_add_seq #(
    parameter int WIDTH = 16,
    localparam int NIB = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_s,
    input  logic             add_cout
);

    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
        $error("nibble_add_seq: WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  bx_q, bx_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              out_valid_q, out_valid_d;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        bx_d        = bx_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        add_a       = 4'd0;
        add_b       = 4'd0;
        add_cin     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + ~borrow through the same adder path.
                    a_d     = op_a;
                    bx_d    = op_sub ? ~op_b : op_b;
                    carry_d = op_sub ^ op_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                add_a   = a_q[4*idx_q +: 4];
                add_b   = bx_q[4*idx_q +: 4];
                add_cin = carry_q;
                sum_d[4*idx_q +: 4] = add_s;
                carry_d = add_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDXW'(NIB - 1)) begin
                    cout_d      = add_cout;
                    ovf_d       = (a_q[WIDTH-1] == bx_q[WIDTH-1]) &&
                                  (add_s[3] != a_q[WIDTH-1]);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Operand registers only change on accept, so they need no reset.
    always_ff @(posedge clk) begin
        a_q  <= a_d;
        bx_q <= bx_d;
    end

    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Bench for nibble_add_seq: WIDTH=16 directed/random scenarios plus an
// exhaustive WIDTH=4 sweep, both against an arithmetic reference model.
module tb_nibble_add_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_pass = 0;
    int   n_total = 0;

    // WIDTH=16 instance
    logic        in_valid, in_ready, op_cin, op_sub, out_valid, out_ready, cout, ovf;
    logic [15:0] op_a, op_b, sum;
    logic [3:0]  add_a, add_b, add_s;
    logic        add_cin, add_cout;

    assign {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    nibble_add_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sub(op_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout)
    );

    // WIDTH=4 instance
    logic       w4_in_valid, w4_in_ready, w4_op_cin, w4_op_sub, w4_out_valid, w4_out_ready;
    logic       w4_cout, w4_ovf, w4_add_cin, w4_add_cout;
    logic [3:0] w4_op_a, w4_op_b, w4_sum, w4_add_a, w4_add_b, w4_add_s;

    assign {w4_add_cout, w4_add_s} = 5'(w4_add_a) + 5'(w4_add_b) + 5'(w4_add_cin);

    nibble_add_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w4_in_valid), .in_ready(w4_in_ready),
        .op_a(w4_op_a), .op_b(w4_op_b), .op_cin(w4_op_cin), .op_sub(w4_op_sub),
        .out_valid(w4_out_valid), .out_ready(w4_out_ready),
        .sum(w4_sum), .cout(w4_cout), .ovf(w4_ovf),
        .add_a(w4_add_a), .add_b(w4_add_b), .add_cin(w4_add_cin),
        .add_s(w4_add_s), .add_cout(w4_add_cout)
    );

    // Reference: {ovf, cout, sum} from plain integer arithmetic on w-bit operands.
    function automatic longint ref_calc(input int w, input longint a, input longint b,
                                        input bit cin, input bit sub);
        longint m, r, s, sa, sb, sr;
        bit co, ov;
        m  = longint'(1) << w;
        r  = sub ? (a - b - longint'(cin)) : (a + b + longint'(cin));
        s  = ((r % m) + m) % m;
        co = sub ? (r >= 0) : (r >= m);
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        sr = sub ? (sa - sb - longint'(cin)) : (sa + sb + longint'(cin));
        ov = (sr < -(m / 2)) || (sr > m / 2 - 1);
        return s | (longint'(co) << w) | (longint'(ov) << (w + 1));
    endfunction

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, output int lat, output logic [15:0] s,
                         output logic co, output logic ov);
        @(negedge clk);
        in_valid = 1'b1; op_a = a; op_b = b; op_cin = cin; op_sub = sub;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        s = sum; co = cout; ov = ovf;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        input logic sub, output int lat, output logic [3:0] s,
                        output logic co, output logic ov);
        @(negedge clk);
        w4_in_valid = 1'b1; w4_op_a = a; w4_op_b = b; w4_op_cin = cin; w4_op_sub = sub;
        @(posedge clk);
        @(negedge clk);
        w4_in_valid = 1'b0;
        lat = 0;
        while (!w4_out_valid && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        s = w4_sum; co = w4_cout; ov = w4_ovf;
        w4_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        w4_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({in_ready, out_valid, sum, cout, ovf, add_a, add_b, add_cin} !== 31'd0) begin
            $display("FAIL reset16: rdy=%b vld=%b sum=%h cout=%b ovf=%b add=%h/%h/%b, want all 0",
                     in_ready, out_valid, sum, cout, ovf, add_a, add_b, add_cin);
        end else n_pass++;
        n_total++;
        if ({w4_in_ready, w4_out_valid, w4_sum, w4_cout, w4_ovf} !== 8'd0) begin
            $display("FAIL reset4: rdy=%b vld=%b sum=%h cout=%b ovf=%b, want all 0",
                     w4_in_ready, w4_out_valid, w4_sum, w4_cout, w4_ovf);
        end else n_pass++;
        rst_n = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [15:0] va[4] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005};
        logic [15:0] vb[4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007};
        logic        vs[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        longint e;
        int lat;
        logic [15:0] s;
        logic co, ov;
        for (int i = 0; i < 4; i++) begin
            run16(va[i], vb[i], 1'b0, vs[i], lat, s, co, ov);
            e = ref_calc(16, longint'(va[i]), longint'(vb[i]), 1'b0, vs[i]);
            n_total++;
            if ({s, co, ov} !== {e[15:0], e[16], e[17]}) begin
                $display("FAIL directed%0d: sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         i, s, co, ov, e[15:0], e[16], e[17]);
            end else n_pass++;
            n_total++;
            if (lat !== 4) $display("FAIL directed%0d_latency: got %0d want 4", i, lat);
            else n_pass++;
        end
    endtask

    task automatic test_adder_ports();
        logic [15:0] a, b, bx;
        logic cin, sub, c0;
        longint e, mk;
        logic [8:0] exp_port, got_port;
        for (int k = 0; k < 3; k++) begin
            a   = (k == 0) ? 16'h0005 : 16'($urandom);
            b   = (k == 0) ? 16'h0007 : 16'($urandom);
            cin = (k == 0) ? 1'b0 : 1'($urandom);
            sub = (k == 0) ? 1'b1 : 1'(k == 1);
            bx  = sub ? ~b : b;
            c0  = sub ? ~cin : cin;
            @(negedge clk);
            in_valid = 1'b1; op_a = a; op_b = b; op_cin = cin; op_sub = sub;
            @(posedge clk);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                in_valid = 1'b0;
                mk = (longint'(1) << (4 * i)) - 1;
                exp_port[8:5] = 4'((longint'(a) >> (4 * i)) & 15);
                exp_port[4:1] = 4'((longint'(bx) >> (4 * i)) & 15);
                exp_port[0]   = (i == 0) ? c0 :
                    1'((((longint'(a) & mk) + (longint'(bx) & mk) + longint'(c0)) >> (4 * i)) & 1);
                got_port = {add_a, add_b, add_cin};
                n_total++;
                if (got_port !== exp_port) begin
                    $display("FAIL adder_ports%0d_nib%0d: a/b/cin=%h/%h/%b want %h/%h/%b",
                             k, i, add_a, add_b, add_cin, exp_port[8:5], exp_port[4:1], exp_port[0]);
                end else n_pass++;
                @(posedge clk);
            end
            @(negedge clk);
            e = ref_calc(16, longint'(a), longint'(b), cin, sub);
            n_total++;
            if ({out_valid, sum, cout, ovf, add_a, add_b, add_cin} !==
                {1'b1, e[15:0], e[16], e[17], 9'd0}) begin
                $display("FAIL adder_ports%0d_done: vld=%b sum=%h cout=%b ovf=%b add=%h/%h/%b want vld=1 sum=%h cout=%b ovf=%b add=0",
                         k, out_valid, sum, cout, ovf, add_a, add_b, add_cin, e[15:0], e[16], e[17]);
            end else n_pass++;
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_hold_backpressure();
        logic [15:0] a1, b1, a2, b2, s;
        longint e1, e2;
        int lat;
        logic co, ov;
        a1 = 16'($urandom); b1 = 16'($urandom);
        a2 = 16'($urandom); b2 = 16'($urandom);
        e1 = ref_calc(16, longint'(a1), longint'(b1), 1'b1, 1'b0);
        e2 = ref_calc(16, longint'(a2), longint'(b2), 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b1; op_a = a1; op_b = b1; op_cin = 1'b1; op_sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        op_a = a2; op_b = b2; op_cin = 1'b0; op_sub = 1'b1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        n_total++;
        if (lat !== 4) $display("FAIL hold_latency: got %0d want 4", lat);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_total++;
            if ({out_valid, in_ready, sum, cout, ovf} !== {1'b1, 1'b0, e1[15:0], e1[16], e1[17]}) begin
                $display("FAIL hold_cycle%0d: vld=%b rdy=%b sum=%h cout=%b ovf=%b want vld=1 rdy=0 sum=%h cout=%b ovf=%b",
                         i, out_valid, in_ready, sum, cout, ovf, e1[15:0], e1[16], e1[17]);
            end else n_pass++;
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL hold_release_same_cycle_ready: got %b want 0", in_ready);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            $display("FAIL hold_release_next: vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end else n_pass++;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        s = sum; co = cout; ov = ovf;
        n_total++;
        if ({lat[4:0], s, co, ov} !== {5'd4, e2[15:0], e2[16], e2[17]}) begin
            $display("FAIL hold_second_op: lat=%0d sum=%h cout=%b ovf=%b want lat=4 sum=%h cout=%b ovf=%b",
                     lat, s, co, ov, e2[15:0], e2[16], e2[17]);
        end else n_pass++;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int lat, seen;
        logic [15:0] s;
        logic co, ov;
        longint e;
        @(negedge clk);
        in_valid = 1'b1; op_a = 16'hFFFF; op_b = 16'h0001; op_cin = 1'b1; op_sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({in_ready, out_valid, sum, cout, ovf, add_a, add_b, add_cin} !== 31'd0) begin
            $display("FAIL reset_mid: rdy=%b vld=%b sum=%h cout=%b ovf=%b add=%h/%h/%b want all 0",
                     in_ready, out_valid, sum, cout, ovf, add_a, add_b, add_cin);
        end else n_pass++;
        rst_n = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_mid_idle: in_ready=%b want 1", in_ready);
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_total++;
        if (seen !== 0) $display("FAIL reset_mid_no_output: out_valid seen %0d cycles want 0", seen);
        else n_pass++;
        run16(16'h1234, 16'h0000, 1'b0, 1'b0, lat, s, co, ov);
        e = ref_calc(16, 64'h1234, 64'h0, 1'b0, 1'b0);
        n_total++;
        if ({lat[4:0], s, co, ov} !== {5'd4, e[15:0], e[16], e[17]}) begin
            $display("FAIL reset_mid_after: lat=%0d sum=%h cout=%b ovf=%b want lat=4 sum=%h cout=%b ovf=%b",
                     lat, s, co, ov, e[15:0], e[16], e[17]);
        end else n_pass++;
    endtask

    task automatic test_random16();
        logic [15:0] a, b, s;
        logic cin, sub, co, ov;
        longint e;
        int lat;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            run16(a, b, cin, sub, lat, s, co, ov);
            e = ref_calc(16, longint'(a), longint'(b), cin, sub);
            n_total++;
            if ({lat[4:0], s, co, ov} !== {5'd4, e[15:0], e[16], e[17]}) begin
                $display("FAIL random16_%0d: a=%h b=%h cin=%b sub=%b got lat=%0d sum=%h cout=%b ovf=%b want lat=4 sum=%h cout=%b ovf=%b",
                         i, a, b, cin, sub, lat, s, co, ov, e[15:0], e[16], e[17]);
            end else n_pass++;
        end
    endtask

    task automatic test_exhaustive4();
        logic [3:0] s;
        logic co, ov;
        longint e;
        int lat;
        for (int sub = 0; sub < 2; sub++)
            for (int cin = 0; cin < 2; cin++)
                for (int a = 0; a < 16; a++)
                    for (int b = 0; b < 16; b++) begin
                        run4(4'(a), 4'(b), 1'(cin), 1'(sub), lat, s, co, ov);
                        e = ref_calc(4, longint'(a), longint'(b), 1'(cin), 1'(sub));
                        n_total++;
                        if ({lat[4:0], s, co, ov} !== {5'd1, e[3:0], e[4], e[5]}) begin
                            $display("FAIL exh4 a=%h b=%h cin=%0d sub=%0d: got lat=%0d sum=%h cout=%b ovf=%b want lat=1 sum=%h cout=%b ovf=%b",
                                     a, b, cin, sub, lat, s, co, ov, e[3:0], e[4], e[5]);
                        end else n_pass++;
                    end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0; op_sub = 1'b0;
        w4_in_valid = 1'b0; w4_out_ready = 1'b0; w4_op_a = '0; w4_op_b = '0;
        w4_op_cin = 1'b0; w4_op_sub = 1'b0;
        test_reset();
        test_directed();
        test_adder_ports();
        test_hold_backpressure();
        test_reset_mid_run();
        test_random16();
        test_exhaustive4();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
